// File: rtl/uart_rx_core.sv
// UART receiver core: 16x-oversampled start/data/parity/stop recovery with
// 2-of-3 mid-bit majority voting, break handling and per-frame error flags.
module uart_rx_core #(
  parameter int DATA_BITS   = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick_16,
  input  logic                 rx,
  input  logic                 parity_en,
  input  logic                 parity_odd,
  output logic [DATA_BITS-1:0] data,
  output logic                 data_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy
);

  // state      | meaning
  // IDLE       | line idle, waiting for a low rx_s on a tick
  // START      | validating the start bit (glitch rejection at count 9)
  // DATA       | shifting in DATA_BITS data bits, LSB first
  // PARITY     | sampling and checking the parity bit
  // STOP       | sampling the stop bit, early exit at count 9
  // BREAK_WAIT | line held low after a bad stop bit, wait for high
  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    START      = 3'd1,
    DATA       = 3'd2,
    PARITY     = 3'd3,
    STOP       = 3'd4,
    BREAK_WAIT = 3'd5
  } state_t;

  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  state_t                 state, state_nxt;
  logic [SYNC_STAGES-1:0] sync;
  logic                   rx_s;
  logic [3:0]             tick_cnt;
  logic [2:0]             bit_cnt;
  logic                   s7, s8, maj_bit, maj_now;
  logic [DATA_BITS-1:0]   shreg;
  logic                   par_en_l, par_odd_l, par_err_int;
  logic                   at_mid, at_end;
  logic                   cnt_clr, bit_clr, shift_en, par_calc, frame_done, latch_cfg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync <= '1;
    else     sync <= {sync[SYNC_STAGES-2:0], rx};
  end

  assign rx_s    = sync[SYNC_STAGES-1];
  assign at_mid  = (tick_cnt == 4'd9);
  assign at_end  = (tick_cnt == 4'd15);
  // third vote is the live count-9 sample, so decisions at count 9 need no extra cycle
  assign maj_now = (s7 & s8) | (s7 & rx_s) | (s8 & rx_s);
  assign busy    = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    cnt_clr    = 1'b0;
    bit_clr    = 1'b0;
    shift_en   = 1'b0;
    par_calc   = 1'b0;
    frame_done = 1'b0;
    latch_cfg  = 1'b0;
    if (tick_16) begin
      case (state)
        IDLE: begin
          cnt_clr = 1'b1;
          if (!rx_s) begin
            state_nxt = START;
            latch_cfg = 1'b1;
          end
        end
        START: begin
          if (at_mid && maj_now) begin
            state_nxt = IDLE;
            cnt_clr   = 1'b1;
          end else if (at_end) begin
            state_nxt = DATA;
            bit_clr   = 1'b1;
          end
        end
        DATA: begin
          if (at_end) begin
            shift_en = 1'b1;
            if (bit_cnt == LAST_BIT) state_nxt = par_en_l ? PARITY : STOP;
          end
        end
        PARITY: begin
          if (at_end) begin
            par_calc  = 1'b1;
            state_nxt = STOP;
          end
        end
        STOP: begin
          if (at_mid) begin
            frame_done = 1'b1;
            cnt_clr    = 1'b1;
            state_nxt  = maj_now ? IDLE : BREAK_WAIT;
          end
        end
        BREAK_WAIT: begin
          cnt_clr = 1'b1;
          if (rx_s) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt    <= 4'd0;
      bit_cnt     <= 3'd0;
      s7          <= 1'b1;
      s8          <= 1'b1;
      maj_bit     <= 1'b1;
      shreg       <= '0;
      par_en_l    <= 1'b0;
      par_odd_l   <= 1'b0;
      par_err_int <= 1'b0;
      data        <= '0;
      data_valid  <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      if (tick_16) begin
        tick_cnt <= cnt_clr ? 4'd0 : tick_cnt + 4'd1;
        if (tick_cnt == 4'd7) s7 <= rx_s;
        if (tick_cnt == 4'd8) s8 <= rx_s;
        if (at_mid)           maj_bit <= maj_now;
      end
      if (latch_cfg) begin
        par_en_l    <= parity_en;
        par_odd_l   <= parity_odd;
        par_err_int <= 1'b0;
      end
      if (bit_clr) bit_cnt <= 3'd0;
      if (shift_en) begin
        shreg   <= {maj_bit, shreg[DATA_BITS-1:1]};
        bit_cnt <= bit_cnt + 3'd1;
      end
      if (par_calc) par_err_int <= ((^shreg) ^ maj_bit) != par_odd_l;
      if (frame_done) begin
        data_valid <= 1'b1;
        data       <= shreg;
        parity_err <= par_en_l & par_err_int;
        frame_err  <= ~maj_now;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_core.sv
// Bench for uart_rx_core: directed frame table, randomized frames against a
// frame-level reference model, plus glitch, break, reset and tick-gating cases.
module tb_uart_rx_core;

  logic       clk = 1'b0;
  logic       rst, tick_16, rx, parity_en, parity_odd;
  logic [7:0] data;
  logic       data_valid, parity_err, frame_err, busy;

  int         n_tests = 0;
  int         n_fail  = 0;
  int         dv_count = 0;
  logic [7:0] got_q[$];
  logic [7:0] last_data;
  logic       last_perr, last_ferr;
  bit         gate = 1'b1;

  uart_rx_core #(.DATA_BITS(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .tick_16(tick_16), .rx(rx),
    .parity_en(parity_en), .parity_odd(parity_odd),
    .data(data), .data_valid(data_valid), .parity_err(parity_err),
    .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  // one tick every 4 clk while gate is open
  initial begin
    int ph = 0;
    tick_16 = 1'b0;
    forever begin
      @(negedge clk);
      if (gate) begin
        ph = (ph + 1) % 4;
        tick_16 = (ph == 0);
      end else begin
        tick_16 = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (data_valid) begin
      dv_count++;
      got_q.push_back(data);
      last_data = data;
      last_perr = parity_err;
      last_ferr = frame_err;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    int guard;
    for (int i = 0; i < n; i++) begin
      guard = 0;
      do begin
        @(posedge clk);
        guard++;
      end while (!tick_16 && guard < 64);
      if (!tick_16) begin
        n_tests++;
        n_fail++;
        $display("FAIL tick_timeout: got no tick in %0d clk, required a tick", guard);
      end
    end
    @(negedge clk);
  endtask

  // reference: frame-level rules, parity by counting ones
  function automatic logic model_perr(input logic [7:0] w, input logic pen,
                                      input logic podd, input logic pbit);
    int ones;
    ones = $countones(w) + int'(pbit);
    if (!pen) return 1'b0;
    return (ones % 2) != (podd ? 1 : 0);
  endfunction

  task automatic send_frame(input logic [7:0] w, input logic pen, input logic podd,
                            input logic pbit, input logic stopv, input bit scramble,
                            input int tail);
    parity_en  = pen;
    parity_odd = podd;
    rx = 1'b0;
    wait_ticks(16);
    if (scramble) begin
      parity_en  = 1'($urandom);
      parity_odd = 1'($urandom);
    end
    for (int i = 0; i < 8; i++) begin
      rx = w[i];
      wait_ticks(16);
    end
    if (pen) begin
      rx = pbit;
      wait_ticks(16);
    end
    rx = stopv;
    wait_ticks(16);
    rx = 1'b1;
    if (tail > 0) wait_ticks(tail);
  endtask

  task automatic check_frame(input string name, input int cnt_before, input logic [7:0] ed,
                             input logic ep, input logic ef);
    check({name, "_dv_count"}, dv_count, cnt_before + 1);
    check({name, "_data"}, last_data, ed);
    check({name, "_parity_err"}, last_perr, ep);
    check({name, "_frame_err"}, last_ferr, ef);
    check({name, "_busy_after"}, busy, 1'b0);
  endtask

  typedef struct {
    logic [7:0] w;
    logic       pen, podd, pbit, stopv;
    logic [7:0] ed;
    logic       ep, ef;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int         c0;
    logic [7:0] w;
    logic       pen, podd, pbit, stopv;
    bit         busy_seen;

    tbl[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
    tbl[1] = '{8'h07, 1'b1, 1'b0, 1'b1, 1'b1, 8'h07, 1'b0, 1'b0};
    tbl[2] = '{8'h07, 1'b1, 1'b0, 1'b0, 1'b1, 8'h07, 1'b1, 1'b0};
    tbl[3] = '{8'h07, 1'b1, 1'b1, 1'b0, 1'b1, 8'h07, 1'b0, 1'b0};
    tbl[4] = '{8'h07, 1'b1, 1'b1, 1'b1, 1'b1, 8'h07, 1'b1, 1'b0};
    tbl[5] = '{8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1};
    tbl[6] = '{8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
    tbl[7] = '{8'h3C, 1'b1, 1'b1, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b0};

    rst = 1'b1; rx = 1'b1; parity_en = 1'b0; parity_odd = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_data", data, 8'h00);
    check("rst_data_valid", data_valid, 1'b0);
    check("rst_parity_err", parity_err, 1'b0);
    check("rst_frame_err", frame_err, 1'b0);
    check("rst_busy", busy, 1'b0);
    rst = 1'b0;
    wait_ticks(4);

    // busy across the baseline frame
    c0 = dv_count;
    busy_seen = 1'b0;
    fork
      send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2);
      begin
        wait_ticks(8);
        busy_seen = busy;
      end
    join
    check("base_busy_mid", busy_seen, 1'b1);
    check_frame("base", c0, 8'hA5, 1'b0, 1'b0);

    for (int i = 0; i < 8; i++) begin
      c0 = dv_count;
      send_frame(tbl[i].w, tbl[i].pen, tbl[i].podd, tbl[i].pbit, tbl[i].stopv, 1'b0, 2);
      check_frame($sformatf("tbl%0d", i), c0, tbl[i].ed, tbl[i].ep, tbl[i].ef);
    end

    for (int i = 0; i < 16; i++) begin
      w     = 8'($urandom);
      pen   = 1'($urandom);
      podd  = 1'($urandom);
      pbit  = 1'($urandom);
      stopv = ($urandom_range(0, 4) != 0);
      c0 = dv_count;
      send_frame(w, pen, podd, pbit, stopv, 1'b1, 2);
      check_frame($sformatf("rand%0d", i), c0, w, model_perr(w, pen, podd, pbit), !stopv);
    end

    // start-bit glitch: 5 ticks low
    parity_en = 1'b0;
    c0 = dv_count;
    rx = 1'b0;
    wait_ticks(5);
    rx = 1'b1;
    wait_ticks(20);
    check("glitch_dv_count", dv_count, c0);
    check("glitch_busy", busy, 1'b0);
    check("glitch_data_held", data, last_data);

    // break: long low, single frame, then a clean frame
    c0 = dv_count;
    rx = 1'b0;
    wait_ticks(200);
    check("break_dv_count", dv_count, c0 + 1);
    check("break_data", last_data, 8'h00);
    check("break_frame_err", last_ferr, 1'b1);
    check("break_busy_hold", busy, 1'b1);
    wait_ticks(100);
    check("break_no_retrigger", dv_count, c0 + 1);
    rx = 1'b1;
    wait_ticks(4);
    check("break_release_busy", busy, 1'b0);
    c0 = dv_count;
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2);
    check_frame("after_break", c0, 8'h3C, 1'b0, 1'b0);

    // reset during data bit 4
    c0 = dv_count;
    w = 8'h5A;
    rx = 1'b0;
    wait_ticks(16);
    for (int i = 0; i < 4; i++) begin
      rx = w[i];
      wait_ticks(16);
    end
    rx = w[4];
    wait_ticks(8);
    check("rstmid_busy_before", busy, 1'b1);
    rst = 1'b1;
    #1;
    check("rstmid_data", data, 8'h00);
    check("rstmid_flags", {data_valid, parity_err, frame_err, busy}, 4'b0000);
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    wait_ticks(160);
    check("rstmid_no_dv", dv_count, c0);
    check("rstmid_idle", busy, 1'b0);
    send_frame(8'h81, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2);
    check_frame("after_rst", c0, 8'h81, 1'b0, 1'b0);

    // back-to-back frames with tick_16 gated off mid-bit
    c0 = dv_count;
    got_q.delete();
    fork
      begin
        send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
        send_frame(8'hAA, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2);
      end
      begin
        wait_ticks(16 * 3 + 5);
        gate = 1'b0;
        repeat (10) @(negedge clk);
        gate = 1'b1;
      end
    join
    check("b2b_dv_count", dv_count, c0 + 2);
    check("b2b_first", (got_q.size() > 0) ? got_q[0] : 8'hxx, 8'h55);
    check("b2b_second", (got_q.size() > 1) ? got_q[1] : 8'hxx, 8'hAA);
    check("b2b_frame_err", last_ferr, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
